// File: rtl/uart_tx_arbiter.sv
// Shares one UART sender between the program loader (direct handshake) and the core (FIFO-buffered).
// Define UART_TX_ARB_RR_EN for round-robin arbitration; otherwise the loader has fixed priority.
module uart_tx_arbiter #(
    parameter int FIFO_DEPTH   = 16,
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        ld_valid,
    input  logic [7:0]                  ld_data,
    output logic                        ld_ready,
    input  logic                        core_valid,
    input  logic [7:0]                  core_data,
    output logic                        core_ready,
    input  logic                        tx_busy,
    output logic                        tx_start,
    output logic [7:0]                  sdata,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        timeout_err
);

    // state     | meaning
    // IDLE      | sender free; arbitrate loader vs core FIFO
    // WAIT_BUSY | start pulse issued; waiting for tx_busy to rise
    // WAIT_DONE | sender busy; waiting for tx_busy to fall

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;
    typedef enum logic {GRANT_LD, GRANT_CORE} grant_t;

    state_t        state;
    grant_t        last_grant;
    logic [TW-1:0] timer;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop;
    logic          grant_ld;
    logic          grant_core;

    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == CW'(FIFO_DEPTH));
    assign core_ready = !fifo_full;
    assign push       = core_valid && !fifo_full;

    always_comb begin
        grant_ld   = 1'b0;
        grant_core = 1'b0;
        if (state == IDLE && !tx_busy) begin
`ifdef UART_TX_ARB_RR_EN
            if (ld_valid && !fifo_empty) begin
                if (last_grant == GRANT_CORE) grant_ld = 1'b1;
                else                          grant_core = 1'b1;
            end else begin
                grant_ld   = ld_valid;
                grant_core = !fifo_empty;
            end
`else
            grant_ld   = ld_valid;
            grant_core = !ld_valid && !fifo_empty;
`endif
        end
    end

`ifndef UART_TX_ARB_RR_EN
    // last_grant is kept for parity with the round-robin build
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    assign ld_ready = grant_ld;
    assign pop      = grant_core;

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= core_data;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            tx_start    <= 1'b0;
            sdata       <= 8'h00;
            timer       <= '0;
            timeout_err <= 1'b0;
            last_grant  <= GRANT_CORE;
        end else begin
            tx_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_ld || grant_core) begin
                        sdata      <= grant_ld ? ld_data : mem[rd_ptr];
                        tx_start   <= 1'b1;
                        timer      <= '0;
                        last_grant <= grant_ld ? GRANT_LD : GRANT_CORE;
                        state      <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (timer == TW'(BUSY_TIMEOUT - 1)) begin
                        // sender never acknowledged; the byte is dropped
                        timer       <= TW'(BUSY_TIMEOUT);
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART sender (tx_start / sdata / tx_busy) between two byte sources: the program loader (handshake, 0x99/0xaa control bytes) and the core's output path (buffered).
- Sits between the loader / core and the UART sender.
- Sequences every byte as one tx_start pulse, then waits for the sender's busy cycle to finish.
- Core bytes pass through an internal FIFO so the core stalls only when the FIFO is full.

Parameters:
- FIFO_DEPTH, 16, core-side FIFO entries; power of two, >= 2.
- BUSY_TIMEOUT, 15, cycles to wait in WAIT_BUSY for tx_busy to rise before abandoning the byte; >= 1.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- ld_valid  input  1  loader has a byte to send.
- ld_data  input  8  loader byte.
- ld_ready  output  1  combinational; loader byte accepted when ld_valid && ld_ready.
- core_valid  input  1  core pushes a byte.
- core_data  input  8  core byte.
- core_ready  output  1  combinational, equals !fifo_full.
- tx_busy  input  1  UART sender busy.
- tx_start  output  1  registered; one-cycle start pulse to the sender.
- sdata  output  8  registered; byte to the sender, stable from the tx_start pulse until the next grant.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current number of core FIFO entries.
- timeout_err  output  1  sticky; set when a BUSY_TIMEOUT expiry occurs.

Behaviour:
- Reset (asynchronous, active-high), all values:
  - state=IDLE, tx_start=0, sdata=8'h00.
  - FIFO read/write pointers=0, fifo_count=0.
  - timeout_err=0, timer=0.
  - last_grant=CORE, so the loader wins the first round-robin tie.
- Reset mid-transfer drops the in-flight byte and all FIFO contents; no tx_start is issued after release until a new grant.
- FIFO push and pop:
  - Push when core_valid && core_ready.
  - Push while full is refused even if a pop occurs in the same cycle.
  - Pop and push in the same cycle leave fifo_count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- States:
  - IDLE: eligible = !tx_busy. The candidate set is {loader if ld_valid, core if FIFO non-empty}.
    - Default arbitration: fixed priority, loader over core.
    - The winner is acknowledged in the same cycle: ld_ready=1 for the loader, or a FIFO pop for the core. ld_ready=0 in every other state and case.
    - At the edge: sdata <= winning byte, tx_start <= 1, timer <= 0, last_grant <= winner, state <= WAIT_BUSY.
    - No candidate: stay in IDLE, tx_start=0.
  - WAIT_BUSY: tx_start is forced to 0 after its single high cycle.
    - tx_busy=1: go to WAIT_DONE.
    - Otherwise timer increments. When timer reaches BUSY_TIMEOUT: timeout_err <= 1, state <= IDLE (the byte is treated as lost).
  - WAIT_DONE: tx_busy=0 -> IDLE; otherwise stay.
- Latency:
  - Byte accepted in cycle N -> tx_start high in cycle N+1.
  - Next grant is possible in the first cycle after tx_busy falls, plus one cycle for the WAIT_DONE->IDLE transition.
- tx_start is never high in two consecutive cycles. Exactly one pulse per accepted byte.
- Loader bytes are never buffered; the loader holds ld_valid / ld_data until ld_ready.
- Core bytes leave in push order.
- timeout_err clears only on reset.

Optional Feature:
- Macro: UART_TX_ARB_RR_EN.
- Defined:
  - Round-robin arbitration in IDLE. When both candidates are present, the requester not equal to last_grant wins.
  - A single candidate always wins.
- Undefined:
  - Fixed priority, loader always over core; the core may starve while ld_valid stays high.
  - last_grant is still maintained but unused.

Test Plan:
- Loader only, sender modelled busy 3 cycles after each start:
  - Stimulus: ld_valid=1, ld_data=8'h99.
  - Required: ld_ready high for 1 cycle; tx_start one cycle later with sdata=8'h99; the next loader byte 8'haa is granted only after tx_busy falls; exactly 2 pulses total.
- Core burst to full (FIFO_DEPTH=16):
  - Stimulus: push 0x00..0x12 back-to-back while the sender is stuck busy.
  - Required: core_ready drops after 16 pushes; fifo_count=16; the sender then receives 0x00..0x0F in order.
- Simultaneous requests:
  - Stimulus: loader 0xAA and core FIFO holding 0x41, 0x42.
  - Required, fixed priority: 0xAA, 0x41, 0x42.
  - Required, with UART_TX_ARB_RR_EN and the loader holding 0xAA, 0xBB: 0xAA, 0x41, 0xBB, 0x42.
- Timeout:
  - Stimulus: tx_busy tied 0 after a grant.
  - Required: timeout_err=1 exactly BUSY_TIMEOUT cycles after entering WAIT_BUSY; the arbiter returns to IDLE and grants the next byte.
- Async reset mid-operation:
  - Stimulus: assert reset in WAIT_DONE with fifo_count=5.
  - Required: outputs clear immediately without a clock edge (tx_start=0, fifo_count=0, timeout_err=0); no tx_start until new requests arrive.
- Simultaneous push/pop at fifo_count=1:
  - Stimulus: core pushes while the arbiter grants from the FIFO in the same cycle.
  - Required: fifo_count stays 1 and byte order is preserved.
